axi_lite_sram: RTL

//  AXI4-Lite slave with an internal word-organised SRAM array. Read and write latency are configurable.

---
 rtl/axi_lite_sram_if.sv | 33 +++
 rtl/axi_lite_sram.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/axi_lite_sram_if.sv
// axi_lite_sram_if: AXI4-Lite bus bundle between a master and the SRAM slave.
//   read address : araddr, arvalid, arready
//   read data    : rdata, rresp, rvalid, rready
//   write address: awaddr, awvalid, awready
//   write data   : wdata, wstrb, wvalid, wready
//   write resp   : bresp, bvalid, bready
interface axi_lite_sram_if #(parameter int DATA_W = 32);
  logic [31:0]         araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [31:0]         awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_sram.sv
// axi_lite_sram: AXI4-Lite slave backed by a word-organised SRAM with configurable latency.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (array contents are kept)
//   bus   : AXI4-Lite slave port (axi_lite_sram_if.slave)
module axi_lite_sram #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          READ_LAT  = 0,
  parameter int          WRITE_LAT = 0
) (
  input logic            clk,
  input logic            rst_n,
  axi_lite_sram_if.slave bus
);
  localparam int          BYTES = DATA_W / 8;
  localparam int          OFF_W = $clog2(BYTES);
  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'(BYTES);
  localparam logic [1:0]  OKAY  = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;
  // Addresses below BASE_ADDR wrap to a huge offset, so one compare covers both bounds.
  function automatic logic in_range(input logic [31:0] a);
    return (64'(a) - 64'(BASE_ADDR)) < SPAN;
  endfunction
  function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> OFF_W);
  endfunction
  logic [DATA_W-1:0] mem [DEPTH];
  // Readies stay low in reset and rise on the first edge after release.
  logic              live_q;
  r_state_e          r_state_q, r_state_d;
  logic [7:0]        rcnt_q, rcnt_d;
  logic [31:0]       raddr_q, raddr_d, rd_addr;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rd_sample;
  w_state_e          w_state_q, w_state_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [31:0]       waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BYTES-1:0]  wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              commit;
  assign bus.arready = live_q && r_state_q == R_IDLE;
  assign bus.rvalid  = r_state_q == R_RESP;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.awready = live_q && w_state_q == W_IDLE && !aw_got_q;
  assign bus.wready  = live_q && w_state_q == W_IDLE && !w_got_q;
  assign bus.bvalid  = w_state_q == W_RESP;
  assign bus.bresp   = bresp_q;
  // With zero read latency the sample happens on the AR handshake edge itself.
  assign rd_addr = r_state_q == R_IDLE ? bus.araddr : raddr_q;
  always_comb begin
    r_state_d = r_state_q;
    rcnt_d    = rcnt_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rd_sample = 1'b0;
    case (r_state_q)
      R_IDLE: if (bus.arvalid && bus.arready) begin
        raddr_d   = bus.araddr;
        rcnt_d    = 8'(READ_LAT);
        rd_sample = READ_LAT == 0;
        r_state_d = READ_LAT == 0 ? R_RESP : R_WAIT;
      end
      R_WAIT: begin
        rcnt_d    = rcnt_q - 8'd1;
        rd_sample = rcnt_q == 8'd1;
        r_state_d = rcnt_q == 8'd1 ? R_RESP : R_WAIT;
      end
      R_RESP: r_state_d = bus.rready ? R_IDLE : R_RESP;
      default: r_state_d = R_IDLE;
    endcase
    if (rd_sample) begin
      rdata_d = in_range(rd_addr) ? mem[idx_of(rd_addr)] : '0;
      rresp_d = in_range(rd_addr) ? OKAY : SLVERR;
    end
  end
  always_comb begin
    w_state_d = w_state_q;
    wcnt_d    = wcnt_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (bus.awvalid && bus.awready) begin
          aw_got_d = 1'b1;
          waddr_d  = bus.awaddr;
        end
        if (bus.wvalid && bus.wready) begin
          w_got_d = 1'b1;
          wdata_d = bus.wdata;
          wstrb_d = bus.wstrb;
        end
        // Leave idle on the edge the second channel is captured.
        if (aw_got_d && w_got_d) begin
          wcnt_d    = 8'(WRITE_LAT);
          w_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        commit    = wcnt_q == 8'd0;
        wcnt_d    = commit ? wcnt_q : wcnt_q - 8'd1;
        bresp_d   = commit ? (in_range(waddr_q) ? OKAY : SLVERR) : bresp_q;
        w_state_d = commit ? W_RESP : W_WAIT;
      end
      W_RESP: if (bus.bready) begin
        aw_got_d  = 1'b0;
        w_got_d   = 1'b0;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q    <= 1'b0;
      r_state_q <= R_IDLE;
      rcnt_q    <= '0;
      raddr_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      w_state_q <= W_IDLE;
      wcnt_q    <= '0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= OKAY;
    end else begin
      live_q    <= 1'b1;
      r_state_q <= r_state_d;
      rcnt_q    <= rcnt_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      w_state_q <= w_state_d;
      wcnt_q    <= wcnt_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end
  // Array write is a plain clocked store; a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (commit && in_range(waddr_q))
      for (int i = 0; i < BYTES; i++)
        if (wstrb_q[i]) mem[idx_of(waddr_q)][8*i +: 8] <= wdata_q[8*i +: 8];
  end
endmodule
